pipe_alu: RTL and testbench

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/pipe_alu.sv | 155 +++++++++++++++
 tb/tb_pipe_alu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu.sv
// Pipelined ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// multiply, with a one-entry valid/ready output register.
module pipe_alu #(
    parameter int unsigned W      = 16,
    parameter int unsigned MUL_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic [W-1:0] out,
    output logic [2:0]   status,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned SHW = $clog2(W);
    localparam int unsigned PW  = 2 * W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    out_q, out_d;
    logic [2:0]      status_q, status_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    alu_res;
    logic            alu_v;
    logic [PW-1:0]   acc_step;
    logic            accept;

    // Single-cycle datapath; op 111 only lands here when the multiplier is disabled.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                alu_res = Ain + Bin;
                alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
            end
            OP_SUB: begin
                alu_res = Ain - Bin;
                alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
            end
            OP_AND:  alu_res = Ain & Bin;
            OP_NOT:  alu_res = ~Bin;
            OP_OR:   alu_res = Ain | Bin;
            OP_XOR:  alu_res = Ain ^ Bin;
            OP_SHL:  alu_res = Ain << Bin[SHW-1:0];
            OP_MUL:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;
        in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((ALUop == OP_MUL) && (MUL_EN != 0)) begin
                        state_d  = MULT;
                        mcand_d  = PW'(Ain);
                        mplier_d = Bin;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_d       = alu_res;
                        status_d    = {(alu_res == '0), alu_v, alu_res[W-1]};
                        out_valid_d = 1'b1;
                    end
                end
            end
            MULT: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + W'(1);
                if (cnt_q == W'(W - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_d       = acc_step[W-1:0];
                    status_d    = {(acc_step[W-1:0] == '0), (|acc_step[PW-1:W]), acc_step[W-1]};
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also aborts an in-flight multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            status_q    <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign status    = status_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == MULT);

endmodule

// File: tb/tb_pipe_alu.sv
// Randomized self-checking bench for pipe_alu against an arithmetic reference model.
module tb_pipe_alu;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic [2:0]   ALUop;
    logic [W-1:0] out;
    logic [2:0]   status;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    pipe_alu #(.W(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Ain       (Ain),
        .Bin       (Bin),
        .ALUop     (ALUop),
        .out       (out),
        .status    (status),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain modular/signed arithmetic, status = {Z, V, N}.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                          output logic [W-1:0] res, output logic [2:0] st);
        longint m    = longint'(1) << W;
        longint half = m / 2;
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = (ua >= half) ? ua - m : ua;
        longint sb   = (ub >= half) ? ub - m : ub;
        longint r    = 0;
        longint p;
        logic   v    = 1'b0;
        case (op)
            3'd0: begin r = (ua + ub) % m; v = (sa + sb >= half) || (sa + sb < -half); end
            3'd1: begin r = (ua - ub + m) % m; v = (sa - sb >= half) || (sa - sb < -half); end
            3'd2: r = ua & ub;
            3'd3: r = (m - 1) - ub;
            3'd4: r = ua | ub;
            3'd5: r = ua ^ ub;
            3'd6: r = (ua << (ub % W)) % m;
            default: begin p = ua * ub; r = p % m; v = (p / m) != 0; end
        endcase
        res = W'(r);
        st  = {(r == 0), v, (r >= half)};
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom % 6)
            0: v = '0;
            1: v = '1;
            2: v = {1'b0, {(W-1){1'b1}}};
            3: v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Issue one op (consuming any prior result), check its result, then optionally stall the consumer.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input int stall);
        logic [W-1:0] er;
        logic [2:0]   es;
        ref_op(a, b, op, er, es);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Ain       = a;
        Bin       = b;
        ALUop     = op;
        #1;
        chk("in_ready_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (op == 3'd7) begin
            for (int i = 0; i < int'(W); i++) begin
                chk("mul_busy", busy, 1);
                chk("mul_in_ready", in_ready, 0);
                chk("mul_out_valid", out_valid, 0);
                in_valid = 1'b1;
                Ain      = W'($urandom);
                Bin      = W'($urandom);
                ALUop    = 3'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        chk("res_valid", out_valid, 1);
        chk("res_out", out, er);
        chk("res_status", status, es);
        chk("res_busy", busy, 0);
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            Ain       = W'($urandom);
            Bin       = W'($urandom);
            ALUop     = 3'($urandom);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk("hold_out", out, er);
                chk("hold_status", status, es);
                chk("hold_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Ain       = '0;
        Bin       = '0;
        ALUop     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_status", status, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Directed corner cases.
        do_op(16'h7FFF, 16'h0001, 3'd0, 0);
        chk("s035_out", out, 16'h8000);
        chk("s035_status", status, 3'b011);
        do_op(16'h0005, 16'h0005, 3'd1, 0);
        chk("s036_sub_status", status, 3'b100);
        do_op(16'h0001, 16'h0013, 3'd6, 0);
        chk("s036_shl_out", out, 16'h0008);
        do_op(16'h012C, 16'h012C, 3'd7, 0);
        chk("s037_out", out, 16'h5F90);
        chk("s037_v", status[1], 1);
        do_op(16'h0001, 16'h0002, 3'd0, 3);
        chk("s038_held", out, 16'h0003);
        do_op(16'h00F0, 16'h0FF0, 3'd2, 0);
        chk("s038_and", out, 16'h00F0);
        for (int i = 0; i < 8; i++) begin
            do_op(W'($urandom), W'($urandom), 3'd5, 0);
        end

        // Reset in the 8th multiply cycle aborts it.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Ain       = 16'h012C;
        Bin       = 16'h012C;
        ALUop     = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out", out, 0);
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_result", out_valid, 0);
        end

        // Randomized mix of ops, operands and consumer stalls.
        for (int i = 0; i < 80; i++) begin
            do_op(pick(), pick(), 3'($urandom), (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Consume the last result with nothing new loaded.
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_valid", out_valid, 0);
        chk("drain_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
